// File: rtl/wrapper_shared_pkg.sv
// Shared constants and types for the SPI slave + RAM wrapper and its upstream driver.
package wrapper_shared_pkg;

    localparam logic ACTIVE_RESET = 1'b0;
    localparam logic INACTIVE     = 1'b1;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned START_LEN = 2;
    localparam int unsigned WORD_LEN  = 10;
    localparam int unsigned RX_LEN    = 8;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StWait,
        StRecv,
        StGap
    } drv_state_e;

    // Counter runs len-1 down to 0, so a phase of len cycles loads len-1.
    function automatic logic [CNT_W-1:0] len_to_cnt(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/spi_master_driver_shift.sv
// Datapath of the SPI driver: parallel-load TX shifter, RX shifter and the shared
// down-counting bit counter that times every FSM phase.
module spi_master_driver_shift
    import wrapper_shared_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WORD_LEN-1:0] word,
    input  logic                tx_shift,
    input  logic                rx_shift,
    input  logic                miso,
    input  logic                cnt_load,
    input  logic [CNT_W-1:0]    cnt_init,
    output logic                mosi,
    output logic [RX_LEN-1:0]   rx_next,
    output logic                cnt_zero
);

    logic [WORD_LEN-1:0] sreg;
    // The eighth received bit goes straight into rsp_data, so only seven are held here.
    logic [RX_LEN-2:0]   rx_q;
    logic [CNT_W-1:0]    cnt_q;

    always_ff @(posedge clk) begin
        if (rst_n == ACTIVE_RESET) begin
            sreg  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (load) begin
                sreg <= word;
            end else if (tx_shift) begin
                // Zero fill leaves sreg clear after the last bit, keeping MOSI low afterwards.
                sreg <= {sreg[WORD_LEN-2:0], 1'b0};
            end

            if (rx_shift) begin
                rx_q <= rx_next[RX_LEN-2:0];
            end

            if (cnt_load) begin
                cnt_q <= cnt_init;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign mosi     = sreg[WORD_LEN-1];
    assign rx_next  = {rx_q, miso};
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/spi_master_driver.sv
// Cycle-exact SPI master that frames 10-bit command words on MOSI under SS_n and, for
// read-data commands, captures the 8-bit MISO reply onto a response port.
module spi_master_driver
    import wrapper_shared_pkg::*;
#(
    parameter int unsigned MISO_START = 2,
    parameter int unsigned GAP        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [9:0] req_word,
    output logic       req_ready,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       frame_done
);

    drv_state_e       state_q;
    logic [1:0]       cmd_q;
    logic             accept;
    logic             load;
    logic             tx_shift;
    logic             rx_shift;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_init;
    logic             cnt_zero;
    logic [7:0]       rx_next;
    logic             is_rd_data;

    assign accept     = req_valid && req_ready;
    assign is_rd_data = (cmd_q == CMD_RD_DATA);

    // Counter reload happens on every state entry, with the length of the phase being entered.
    always_comb begin
        load     = 1'b0;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        cnt_load = 1'b0;
        cnt_init = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    load     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_init = len_to_cnt(START_LEN);
                end
            end
            StStart: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_init = len_to_cnt(WORD_LEN);
                end
            end
            StShift: begin
                tx_shift = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_init = is_rd_data ? len_to_cnt(MISO_START) : len_to_cnt(GAP);
                end
            end
            StWait: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_init = len_to_cnt(RX_LEN);
                end
            end
            StRecv: begin
                rx_shift = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_init = len_to_cnt(GAP);
                end
            end
            StGap: begin
                cnt_load = 1'b0;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n == ACTIVE_RESET) begin
            state_q    <= StIdle;
            cmd_q      <= CMD_WR_ADDR;
            SS_n       <= INACTIVE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rsp_valid  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q   <= StStart;
                        cmd_q     <= req_word[9:8];
                        SS_n      <= ~INACTIVE;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        SS_n      <= INACTIVE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_zero) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_zero) begin
                        if (is_rd_data) begin
                            state_q <= StWait;
                        end else begin
                            state_q    <= StGap;
                            SS_n       <= INACTIVE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (cnt_zero) begin
                        state_q <= StRecv;
                    end
                end
                StRecv: begin
                    if (cnt_zero) begin
                        state_q    <= StGap;
                        SS_n       <= INACTIVE;
                        frame_done <= 1'b1;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= rx_next;
                    end
                end
                StGap: begin
                    if (cnt_zero) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    SS_n    <= INACTIVE;
                end
            endcase
        end
    end

    spi_master_driver_shift u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .word     (req_word),
        .tx_shift (tx_shift),
        .rx_shift (rx_shift),
        .miso     (MISO),
        .cnt_load (cnt_load),
        .cnt_init (cnt_init),
        .mosi     (MOSI),
        .rx_next  (rx_next),
        .cnt_zero (cnt_zero)
    );

endmodule

// File: tb/tb_spi_master_driver.sv
// Directed bench for spi_master_driver: default instance plus a MISO_START=3, GAP=4 variant.
module tb_spi_master_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] ss_n;
    logic [1:0] mosi;
    logic [1:0] miso;
    logic [1:0] rsp_valid;
    logic [1:0] busy;
    logic [1:0] frame_done;
    logic [9:0] req_word [2];
    logic [7:0] rsp_data [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_driver #(.MISO_START(2), .GAP(1)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[0]),
        .req_word   (req_word[0]),
        .req_ready  (req_ready[0]),
        .SS_n       (ss_n[0]),
        .MOSI       (mosi[0]),
        .MISO       (miso[0]),
        .rsp_valid  (rsp_valid[0]),
        .rsp_data   (rsp_data[0]),
        .busy       (busy[0]),
        .frame_done (frame_done[0])
    );

    spi_master_driver #(.MISO_START(3), .GAP(4)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid[1]),
        .req_word   (req_word[1]),
        .req_ready  (req_ready[1]),
        .SS_n       (ss_n[1]),
        .MOSI       (mosi[1]),
        .MISO       (miso[1]),
        .rsp_valid  (rsp_valid[1]),
        .rsp_data   (rsp_data[1]),
        .busy       (busy[1]),
        .frame_done (frame_done[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d, input string tag);
        int guard = 0;
        while (!req_ready[d] && guard < 100) begin
            step();
            guard++;
        end
        check_eq(tag, 32'(guard < 100), 1);
    endtask

    // One full frame: handshake, SS_n-low phase (MOSI capture, MISO drive), then the gap.
    task automatic do_frame(input int d, input logic [9:0] w, input logic [7:0] mb, input int ms,
                            output int low_len, output logic [9:0] mw, output logic fd0,
                            output logic rv0, output logic [7:0] rd0, output int gap_len,
                            output logic extra);
        int k;
        req_word[d]  = w;
        req_valid[d] = 1'b1;
        wait_ready(d, "frame_ready_timeout");
        step();
        req_valid[d] = 1'b0;
        low_len = 0;
        mw      = '0;
        while (ss_n[d] == 1'b0 && low_len < 100) begin
            low_len++;
            if (low_len >= 3 && low_len <= 12) mw[12 - low_len] = mosi[d];
            k = low_len - (13 + ms);
            miso[d] = (k >= 0 && k < 8) ? mb[7 - k] : 1'b0;
            step();
        end
        miso[d] = 1'b0;
        fd0     = frame_done[d];
        rv0     = rsp_valid[d];
        rd0     = rsp_data[d];
        gap_len = 0;
        extra   = 1'b0;
        while (busy[d] && gap_len < 100) begin
            gap_len++;
            if (mosi[d] || !ss_n[d]) extra = 1'b1;
            if (gap_len > 1 && (rsp_valid[d] || frame_done[d])) extra = 1'b1;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         low, gl, low1, high, low2, lowcnt;
        logic [9:0] mw;
        logic       fd0, rv0, extra, pulse_seen;
        logic [7:0] rd0;

        rst_n     = 1'b0;
        req_valid = '0;
        miso      = '0;
        req_word[0] = '0;
        req_word[1] = '0;
        repeat (3) step();

        check_eq("rst_ss_n",       ss_n[0],       1);
        check_eq("rst_mosi",       mosi[0],       0);
        check_eq("rst_req_ready",  req_ready[0],  0);
        check_eq("rst_rsp_valid",  rsp_valid[0],  0);
        check_eq("rst_rsp_data",   rsp_data[0],   0);
        check_eq("rst_busy",       busy[0],       0);
        check_eq("rst_frame_done", frame_done[0], 0);
        check_eq("rst_ss_n_v",     ss_n[1],       1);

        rst_n = 1'b1;
        step();
        check_eq("post_rst_ready",   req_ready[0], 1);
        check_eq("post_rst_ready_v", req_ready[1], 1);

        // Write-address 0x03C
        do_frame(0, 10'h03C, 8'h00, 2, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("wa_low_len",    low,   12);
        check_eq("wa_mosi_word",  mw,    10'h03C);
        check_eq("wa_frame_done", fd0,   1);
        check_eq("wa_no_rsp",     rv0,   0);
        check_eq("wa_gap_len",    gl,    1);
        check_eq("wa_gap_clean",  extra, 0);
        check_eq("wa_idle_ready", req_ready[0], 1);

        // Write 0xA7 to address 0x5A, then read it back through MISO
        do_frame(0, 10'h05A, 8'h00, 2, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("wa2_mosi_word", mw, 10'h05A);
        do_frame(0, 10'h1A7, 8'h00, 2, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("wd_low_len",   low, 12);
        check_eq("wd_mosi_word", mw,  10'h1A7);
        do_frame(0, 10'h300, 8'hA7, 2, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("rd_low_len",    low,   22);
        check_eq("rd_mosi_word",  mw,    10'h300);
        check_eq("rd_frame_done", fd0,   1);
        check_eq("rd_rsp_valid",  rv0,   1);
        check_eq("rd_rsp_data",   rd0,   8'hA7);
        check_eq("rd_gap_len",    gl,    1);
        check_eq("rd_gap_clean",  extra, 0);

        // rsp_data holds across a non-read frame
        do_frame(0, 10'h0FF, 8'h55, 2, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("hold_no_rsp",    rv0, 0);
        check_eq("hold_rsp_data",  rsp_data[0], 8'hA7);
        check_eq("ra_mosi_word",   mw, 10'h0FF);

        // Back-to-back with req_valid held
        req_word[0]  = 10'h15A;
        req_valid[0] = 1'b1;
        wait_ready(0, "b2b_ready_timeout");
        step();
        req_word[0] = 10'h25A;
        low1 = 0;
        while (ss_n[0] == 1'b0 && low1 < 100) begin low1++; step(); end
        high = 0;
        while (ss_n[0] == 1'b1 && high < 100) begin high++; step(); end
        req_valid[0] = 1'b0;
        low2 = 0;
        while (ss_n[0] == 1'b0 && low2 < 100) begin low2++; step(); end
        check_eq("b2b_low1", low1, 12);
        check_eq("b2b_high", high, 2);
        check_eq("b2b_low2", low2, 12);
        wait_ready(0, "b2b_idle_timeout");

        // req_valid while busy is ignored
        req_word[0]  = 10'h03C;
        req_valid[0] = 1'b1;
        wait_ready(0, "ign_ready_timeout");
        step();
        req_word[0] = 10'h155;
        lowcnt = 0;
        mw     = '0;
        for (int n = 1; n <= 40; n++) begin
            if (ss_n[0] == 1'b0) lowcnt++;
            if (n >= 3 && n <= 12) mw[12 - n] = mosi[0];
            if (n == 6) req_valid[0] = 1'b0;
            step();
        end
        check_eq("ign_low_len",   lowcnt, 12);
        check_eq("ign_mosi_word", mw,     10'h03C);
        check_eq("ign_idle_ss_n", ss_n[0], 1);
        do_frame(0, 10'h155, 8'h00, 2, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("ign_next_low",  low, 12);
        check_eq("ign_next_word", mw,  10'h155);

        // Reset in frame cycle 7 of 0x0A5
        req_word[0]  = 10'h0A5;
        req_valid[0] = 1'b1;
        wait_ready(0, "mrst_ready_timeout");
        step();
        req_valid[0] = 1'b0;
        repeat (6) step();
        check_eq("mrst_in_frame", ss_n[0], 0);
        rst_n = 1'b0;
        step();
        check_eq("mrst_ss_n",       ss_n[0],       1);
        check_eq("mrst_mosi",       mosi[0],       0);
        check_eq("mrst_busy",       busy[0],       0);
        check_eq("mrst_frame_done", frame_done[0], 0);
        check_eq("mrst_req_ready",  req_ready[0],  0);
        rst_n = 1'b1;
        step();
        check_eq("mrst_release_ready", req_ready[0], 1);
        pulse_seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (frame_done[0] || rsp_valid[0] || !ss_n[0]) pulse_seen = 1'b1;
            step();
        end
        check_eq("mrst_no_pulse", pulse_seen, 0);

        // MISO_START = 3, GAP = 4 variant
        do_frame(1, 10'h300, 8'h3C, 3, low, mw, fd0, rv0, rd0, gl, extra);
        check_eq("v_low_len",    low,   23);
        check_eq("v_mosi_word",  mw,    10'h300);
        check_eq("v_frame_done", fd0,   1);
        check_eq("v_rsp_valid",  rv0,   1);
        check_eq("v_rsp_data",   rd0,   8'h3C);
        check_eq("v_gap_len",    gl,    4);
        check_eq("v_gap_clean",  extra, 0);
        check_eq("v_idle_ready", req_ready[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
